// File: rtl/tcam_pkg.sv
// Shared types and constants for the 16x8 routing TCAM programming path.
// Loader states, geometry constants and the stored entry layout.
package tcam_pkg;

   localparam int ID_WIDTH     = 4;
   localparam int BITS         = 2 * ID_WIDTH;
   localparam int WORDS        = 16;
   localparam int ADDR_SIZE    = 4;
   localparam int FLUSH_CYCLES = 2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FLUSH   = 3'd1,
      ST_LOAD    = 3'd2,
      ST_WRITE   = 3'd3,
      ST_CHECK   = 3'd4,
      ST_CHKWAIT = 3'd5,
      ST_DONE    = 3'd6
   } loader_state_e;

   typedef struct packed {
      logic [ID_WIDTH-1:0] key;
      logic [ID_WIDTH-1:0] mask;
      logic [ID_WIDTH-1:0] dst;
   } tcam_entry_t;

   // TCAM data word layout: match key in the upper half, destination in the lower half.
   function automatic logic [BITS-1:0] entry_word(input tcam_entry_t e);
      return {e.key, e.dst};
   endfunction

endpackage

// File: rtl/tcam_table_loader.sv
// Programming-side master for the routing TCAM: flush, then write streamed {key,dst} entries.
// Optional write-verify readback is enabled with `define TCAM_LOADER_READBACK_EN.
module tcam_table_loader
   import tcam_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_start,
   input  logic                  ent_valid,
   output logic                  ent_ready,
   input  logic [ID_WIDTH-1:0]   ent_key,
   input  logic [ID_WIDTH-1:0]   ent_mask,
   input  logic [ID_WIDTH-1:0]   ent_dst,
   input  logic                  ent_last,
   output logic                  busy,
   output logic                  done,
   output logic                  full,
   output logic                  err,
   output logic [ADDR_SIZE:0]    entry_count,
   output logic                  tcam_cs,
   output logic                  tcam_flush,
   output logic                  tcam_wr,
   output logic                  tcam_vbi,
   output logic                  tcam_vbe,
   output logic                  tcam_dcs,
   output logic                  tcam_cmp,
   output logic [BITS-1:0]       tcam_di,
   output logic [BITS-1:0]       tcam_mskb,
   output logic [ADDR_SIZE-1:0]  tcam_a,
   input  logic                  tcam_hit
);

   localparam logic [ADDR_SIZE:0] COUNT_FULL = (ADDR_SIZE+1)'(WORDS);
   localparam logic [1:0]         FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

   loader_state_e         state_q, state_d;
   logic [1:0]            flush_cnt_q, flush_cnt_d;
   tcam_entry_t           entry_q, entry_d;
   logic                  last_q, last_d;
   logic [ADDR_SIZE:0]    count_q, count_d;
   logic                  err_q, err_d;

   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  full_q, full_d;
   logic                  ready_q, ready_d;
   logic                  cs_q, cs_d;
   logic                  flush_q, flush_d;
   logic                  wr_q, wr_d;
   logic                  cmp_q, cmp_d;
   logic                  verify_s;
   logic [BITS-1:0]       di_q, di_d;
   logic [BITS-1:0]       mskb_q, mskb_d;
   logic [ADDR_SIZE-1:0]  a_q, a_d;

`ifndef TCAM_LOADER_READBACK_EN
   logic                  unused_hit;
   assign unused_hit = tcam_hit;
`endif

   // Next-state logic, then every output computed from the state being entered.
   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      entry_d     = entry_q;
      last_d      = last_q;
      count_d     = count_q;
      err_d       = err_q;

      case (state_q)
         ST_IDLE: begin
            if (cfg_start) begin
               state_d     = ST_FLUSH;
               flush_cnt_d = 2'd0;
               err_d       = 1'b0;
               count_d     = '0;
            end else begin
               state_d     = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            if (flush_cnt_q == FLUSH_LAST) begin
               state_d     = ST_LOAD;
            end else begin
               flush_cnt_d = flush_cnt_q + 2'd1;
            end
         end
         ST_LOAD: begin
            // A full table cannot take the offered entry: flag overflow and close the session.
            if (ent_valid && (count_q == COUNT_FULL)) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else if (ent_valid) begin
               entry_d = '{key: ent_key, mask: ent_mask, dst: ent_dst};
               last_d  = ent_last;
               state_d = ST_WRITE;
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_WRITE: begin
            count_d = count_q + (ADDR_SIZE+1)'(1);
`ifdef TCAM_LOADER_READBACK_EN
            state_d = ST_CHECK;
`else
            state_d = last_q ? ST_DONE : ST_LOAD;
`endif
         end
`ifdef TCAM_LOADER_READBACK_EN
         ST_CHECK: begin
            state_d = ST_CHKWAIT;
         end
         ST_CHKWAIT: begin
            if (!tcam_hit) begin
               err_d = 1'b1;
            end else begin
               err_d = err_q;
            end
            state_d = last_q ? ST_DONE : ST_LOAD;
         end
`endif
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d  = (state_d != ST_IDLE);
      cs_d    = (state_d != ST_IDLE);
      flush_d = (state_d == ST_FLUSH);
      wr_d    = (state_d == ST_WRITE);
      done_d  = (state_d == ST_DONE);
      full_d  = (count_d == COUNT_FULL);
      ready_d = (state_d == ST_LOAD) && (count_d != COUNT_FULL);
      a_d     = count_d[ADDR_SIZE-1:0];
`ifdef TCAM_LOADER_READBACK_EN
      cmp_d    = (state_d == ST_CHECK);
      verify_s = (state_d == ST_CHECK) || (state_d == ST_CHKWAIT);
`else
      cmp_d    = 1'b0;
      verify_s = 1'b0;
`endif
      // Readback searches for the key alone, so dst is zeroed and only key bits are compared.
      if (verify_s) begin
         di_d   = {entry_d.key, {ID_WIDTH{1'b0}}};
         mskb_d = {{ID_WIDTH{1'b1}}, {ID_WIDTH{1'b0}}};
      end else begin
         di_d   = entry_word(entry_d);
         mskb_d = {entry_d.mask, {ID_WIDTH{1'b0}}};
      end
   end

   // State, entry and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         flush_cnt_q <= 2'd0;
         entry_q     <= '0;
         last_q      <= 1'b0;
         count_q     <= '0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         full_q      <= 1'b0;
         ready_q     <= 1'b0;
         cs_q        <= 1'b0;
         flush_q     <= 1'b0;
         wr_q        <= 1'b0;
         cmp_q       <= 1'b0;
         di_q        <= '0;
         mskb_q      <= '0;
         a_q         <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         entry_q     <= entry_d;
         last_q      <= last_d;
         count_q     <= count_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         full_q      <= full_d;
         ready_q     <= ready_d;
         cs_q        <= cs_d;
         flush_q     <= flush_d;
         wr_q        <= wr_d;
         cmp_q       <= cmp_d;
         di_q        <= di_d;
         mskb_q      <= mskb_d;
         a_q         <= a_d;
      end
   end

   assign ent_ready   = ready_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign full        = full_q;
   assign err         = err_q;
   assign entry_count = count_q;
   assign tcam_cs     = cs_q;
   assign tcam_flush  = flush_q;
   assign tcam_wr     = wr_q;
   assign tcam_vbi    = wr_q;
   assign tcam_vbe    = wr_q;
   assign tcam_dcs    = wr_q;
   assign tcam_cmp    = cmp_q;
   assign tcam_di     = di_q;
   assign tcam_mskb   = mskb_q;
   assign tcam_a      = a_q;

endmodule
